// File: rtl/l1d_port_arbiter.sv
// l1d_port_arbiter: shares the single L1D data RAM port between the EX-stage
// load/store unit (M0, fixed high priority) and the debug/DMA loader (M1).
// A starvation counter forces a grant to M1 after STARVE_LIMIT consecutive
// losses. Misaligned half/word requests are rejected without touching the RAM.
// Read data returns one cycle after the grant and is steered to the requester
// that issued the read.
module l1d_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // M0: EX-stage load/store unit
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic [1:0]        m0_type_i,
  output logic              m0_gnt_o,
  output logic              m0_err_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  // M1: debug / DMA loader
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic [1:0]        m1_type_i,
  output logic              m1_gnt_o,
  output logic              m1_err_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  // L1D write side
  output logic              l1d_we_o,
  output logic [ADDR_W-1:0] l1d_waddr_o,
  output logic [DATA_W-1:0] l1d_wdata_o,
  output logic [1:0]        l1d_wtype_o,
  // L1D read side
  output logic              l1d_re_o,
  output logic [ADDR_W-1:0] l1d_raddr_o,
  output logic [1:0]        l1d_rtype_o,
  input  logic [DATA_W-1:0] l1d_rdata_i
);

  // Access size encoding shared with the L1D; code 2'd3 is treated as
  // misaligned so an undefined size can never reach the RAM.
  localparam logic [1:0] TYPE_BYTE = 2'd0;
  localparam logic [1:0] TYPE_HALF = 2'd1;
  localparam logic [1:0] TYPE_WORD = 2'd2;

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  // Per-requester views so the alignment and steering logic is written once.
  logic [1:0]        req_v;
  logic [1:0]        we_v;
  logic [ADDR_W-1:0] addr_v  [2];
  logic [DATA_W-1:0] wdata_v [2];
  logic [1:0]        type_v  [2];
  logic [DATA_W-1:0] rdata_v [2];

  logic [1:0] aligned;
  logic [1:0] cand;
  logic [1:0] err;
  logic [1:0] gnt;
  logic [1:0] rvalid;
  logic       win;
  logic       any_gnt;
  logic       rd_fire;

  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             rd_pend_reg, rd_pend_next;
  logic             rd_owner_reg, rd_owner_next;

  assign req_v      = {m1_req_i, m0_req_i};
  assign we_v       = {m1_we_i, m0_we_i};
  assign addr_v[0]  = m0_addr_i;
  assign addr_v[1]  = m1_addr_i;
  assign wdata_v[0] = m0_wdata_i;
  assign wdata_v[1] = m1_wdata_i;
  assign type_v[0]  = m0_type_i;
  assign type_v[1]  = m1_type_i;

  // Per-requester alignment check, reject/candidate split and read-data steering.
  // Everything is gated by rst so nothing leaks out while reset is held.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign aligned[gi] = (type_v[gi] == TYPE_BYTE) ||
                           ((type_v[gi] == TYPE_HALF) && !addr_v[gi][0]) ||
                           ((type_v[gi] == TYPE_WORD) && (addr_v[gi][1:0] == 2'b00));
      assign err[gi]     = rst & req_v[gi] & ~aligned[gi];
      assign cand[gi]    = rst & req_v[gi] & aligned[gi];
      assign rvalid[gi]  = rst & rd_pend_reg & (rd_owner_reg == 1'(gi));
      assign rdata_v[gi] = rvalid[gi] ? l1d_rdata_i : '0;
    end
  endgenerate

  // M1 wins when it is alone, or when it has lost STARVE_LIMIT times in a row.
  assign win     = cand[1] & (~cand[0] | (starve_cnt_reg == CNT_MAX));
  assign gnt     = {win, cand[0] & ~win};
  assign any_gnt = |gnt;

  // The winner drives the RAM port directly in the grant cycle.
  assign l1d_we_o    = any_gnt &  we_v[win];
  assign l1d_re_o    = any_gnt & ~we_v[win];
  assign l1d_waddr_o = addr_v[win];
  assign l1d_wdata_o = wdata_v[win];
  assign l1d_wtype_o = type_v[win];
  assign l1d_raddr_o = addr_v[win];
  assign l1d_rtype_o = type_v[win];
  assign rd_fire     = l1d_re_o;

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign m0_err_o    = err[0];
  assign m1_err_o    = err[1];
  assign m0_rvalid_o = rvalid[0];
  assign m1_rvalid_o = rvalid[1];
  assign m0_rdata_o  = rdata_v[0];
  assign m1_rdata_o  = rdata_v[1];

  // Next-state: starvation counter, and the one-deep pending-read tracker.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    rd_pend_next    = rd_fire;
    rd_owner_next   = rd_fire ? win : rd_owner_reg;
    if (gnt[1]) begin
      starve_cnt_next = '0;
    end else if ((cand == 2'b11) && (starve_cnt_reg != CNT_MAX)) begin
      starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end
  end

  // State registers; reset discards any read still in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_reg <= '0;
      rd_pend_reg    <= 1'b0;
      rd_owner_reg   <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      rd_pend_reg    <= rd_pend_next;
      rd_owner_reg   <= rd_owner_next;
    end
  end

endmodule
